// File: rtl/prog_loader_if.sv
// Byte-stream and cache write-port bundle for prog_loader.
// master : byte source (drives in_valid/in_data) that also observes the cache write ports.
// slave  : the loader (accepts bytes, drives in_ready and both cache write ports).
//   in_valid/in_data/in_ready : valid/ready byte stream; a transfer is in_valid && in_ready
//   IData_in/IAddr_in/icache_we : instruction-cache word write port
//   DData_in/DAddr_in/dcache_we : data-cache word write port
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] IData_in;
  logic [31:0] IAddr_in;
  logic        icache_we;
  logic [31:0] DData_in;
  logic [31:0] DAddr_in;
  logic        dcache_we;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  IData_in, IAddr_in, icache_we,
    input  DData_in, DAddr_in, dcache_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output IData_in, IAddr_in, icache_we,
    output DData_in, DAddr_in, dcache_we
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. Decodes framed commands from a byte stream and
// writes instruction/data words into the caches, then raises start on RUN.
// Frame (big-endian): CMD, CNT_HI, CNT_LO, BASE_HI, BASE_LO, CNT x 4-byte words.
//   CMD 'I' (8'h49) -> I-cache, 'D' (8'h44) -> D-cache, 'G' (8'h47) -> run.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   bus   : prog_loader_if.slave (byte stream in, cache write ports out)
//   start : processor run enable, sticky until reset
//   busy  : a segment is in progress (count/base/word/write phases)
//   error : sticky protocol error
// All outputs are registered.
module prog_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus,
  output logic         start,
  output logic         busy,
  output logic         error
);

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_BASE_HI, S_BASE_LO,
    S_WORD, S_WRITE, S_RUN, S_ERROR
  } state_e;

  state_e      state_r;
  logic        tgt_d_r;     // 1: D-cache target, 0: I-cache target
  logic [15:0] cnt_r;
  logic [15:0] base_r;      // [15:8] doubles as BASE_HI holding until BASE_LO arrives
  logic [15:0] k_r;         // word index within the segment
  logic [1:0]  byte_idx_r;
  logic [23:0] asm_r;       // first three bytes; the 4th goes straight to the output

  logic        xfer_s;
  logic [15:0] base_full_s;
  logic [16:0] lim_s;
  logic [15:0] addr_s;

  // Segment must end at or below the depth; 17-bit sum so it never wraps.
  function automatic logic seg_fits(input logic [15:0] base,
                                    input logic [15:0] cnt,
                                    input logic [16:0] lim);
    return (({1'b0, base} + {1'b0, cnt}) <= lim);
  endfunction

  assign xfer_s = bus.in_valid && bus.in_ready;

  // Depth limit of the latched target, full base and current write address.
  always_comb begin
    lim_s       = IMEM_LIM;
    base_full_s = {base_r[15:8], bus.in_data};
    addr_s      = base_r + k_r;
    if (tgt_d_r) begin
      lim_s = DMEM_LIM;
    end else begin
      lim_s = IMEM_LIM;
    end
  end

  // Loader FSM with registered handshake, status and cache write outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      tgt_d_r       <= 1'b0;
      cnt_r         <= 16'd0;
      base_r        <= 16'd0;
      k_r           <= 16'd0;
      byte_idx_r    <= 2'd0;
      asm_r         <= 24'd0;
      bus.in_ready  <= 1'b1;
      bus.IData_in  <= 32'd0;
      bus.IAddr_in  <= 32'd0;
      bus.icache_we <= 1'b0;
      bus.DData_in  <= 32'd0;
      bus.DAddr_in  <= 32'd0;
      bus.dcache_we <= 1'b0;
      start         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.icache_we <= 1'b0;
      bus.dcache_we <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (xfer_s) begin
            case (bus.in_data)
              8'h49: begin
                tgt_d_r <= 1'b0;
                state_r <= S_CNT_HI;
                busy    <= 1'b1;
              end
              8'h44: begin
                tgt_d_r <= 1'b1;
                state_r <= S_CNT_HI;
                busy    <= 1'b1;
              end
              8'h47: begin
                state_r      <= S_RUN;
                start        <= 1'b1;
                bus.in_ready <= 1'b0;
              end
              default: begin
                state_r      <= S_ERROR;
                error        <= 1'b1;
                bus.in_ready <= 1'b0;
              end
            endcase
          end
        end
        S_CNT_HI: begin
          if (xfer_s) begin
            cnt_r[15:8] <= bus.in_data;
            state_r     <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer_s) begin
            cnt_r[7:0] <= bus.in_data;
            state_r    <= S_BASE_HI;
          end
        end
        S_BASE_HI: begin
          if (xfer_s) begin
            base_r[15:8] <= bus.in_data;
            state_r      <= S_BASE_LO;
          end
        end
        S_BASE_LO: begin
          if (xfer_s) begin
            base_r <= base_full_s;
            if (cnt_r == 16'd0) begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end else if (!seg_fits(base_full_s, cnt_r, lim_s)) begin
              state_r      <= S_ERROR;
              error        <= 1'b1;
              busy         <= 1'b0;
              bus.in_ready <= 1'b0;
            end else begin
              state_r    <= S_WORD;
              k_r        <= 16'd0;
              byte_idx_r <= 2'd0;
            end
          end
        end
        S_WORD: begin
          if (xfer_s) begin
            if (byte_idx_r == 2'd3) begin
              // Strobe is registered here so it is high during the WRITE cycle.
              if (tgt_d_r) begin
                bus.DData_in  <= {asm_r, bus.in_data};
                bus.DAddr_in  <= {16'd0, addr_s};
                bus.dcache_we <= 1'b1;
              end else begin
                bus.IData_in  <= {asm_r, bus.in_data};
                bus.IAddr_in  <= {16'd0, addr_s};
                bus.icache_we <= 1'b1;
              end
              byte_idx_r   <= 2'd0;
              state_r      <= S_WRITE;
              bus.in_ready <= 1'b0;
            end else begin
              asm_r      <= {asm_r[15:0], bus.in_data};
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
        end
        S_WRITE: begin
          k_r          <= k_r + 16'd1;
          bus.in_ready <= 1'b1;
          if ((k_r + 16'd1) == cnt_r) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= S_WORD;
          end
        end
        S_RUN: begin
          state_r <= S_RUN;
        end
        S_ERROR: begin
          state_r <= S_ERROR;
        end
        default: begin
          // Unreachable encoding: park safely in ERROR.
          state_r      <= S_ERROR;
          error        <= 1'b1;
          busy         <= 1'b0;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames, a scoreboard queue of
// expected cache writes, and a monitor that pops/compares on every strobe.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst;
  logic start, busy, error;

  prog_loader_if bus();

  prog_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .start(start),
    .busy (busy),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          errors = 0;
  int          i_pulses = 0;
  int          d_pulses = 0;
  logic [31:0] last_i_data = 32'd0, last_i_addr = 32'd0;
  logic [31:0] last_d_data = 32'd0, last_d_addr = 32'd0;
  bit          gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin : monitor
    wr_t got;
    wr_t e;
    if (bus.icache_we || bus.dcache_we) begin
      if (bus.icache_we) i_pulses++;
      if (bus.dcache_we) d_pulses++;
      check("one_strobe", {63'd0, bus.icache_we && bus.dcache_we}, 64'd0);
      got.is_d = bus.dcache_we;
      got.addr = bus.dcache_we ? bus.DAddr_in : bus.IAddr_in;
      got.data = bus.dcache_we ? bus.DData_in : bus.IData_in;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        check("wr_target", {63'd0, got.is_d}, {63'd0, e.is_d});
        check("wr_addr", {32'd0, got.addr}, {32'd0, e.addr});
        check("wr_data", {32'd0, got.data}, {32'd0, e.data});
        if (e.is_d) begin
          check("i_port_hold", {bus.IData_in, bus.IAddr_in}, {last_i_data, last_i_addr});
          last_d_data = e.data;
          last_d_addr = e.addr;
        end else begin
          check("d_port_hold", {bus.DData_in, bus.DAddr_in}, {last_d_data, last_d_addr});
          last_i_data = e.data;
          last_i_addr = e.addr;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    int budget;
    if (gaps) begin
      n = $urandom_range(0, 3);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat (n) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %0h", b);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Sends a full segment from 'words'; expected writes go to base+i.
  task automatic send_seg(input logic [7:0] cmd, input logic [15:0] base);
    logic [15:0] cnt;
    cnt = 16'(words.size());
    send_byte(cmd);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    if (cnt != 16'd0) check("busy_in_seg", {63'd0, busy}, 64'd1);
    foreach (words[i]) begin
      exp_q.push_back({(cmd == 8'h44), 32'(base) + 32'(i), words[i]});
      send_word(words[i]);
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    last_i_data = 32'd0; last_i_addr = 32'd0;
    last_d_data = 32'd0; last_d_addr = 32'd0;
    check("rst_ctrl", {58'd0, start, busy, error, bus.in_ready, bus.icache_we, bus.dcache_we},
          {58'd0, 6'b000100});
    check("rst_iport", {bus.IData_in, bus.IAddr_in}, 64'd0);
    check("rst_dport", {bus.DData_in, bus.DAddr_in}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ip;
    int dp;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // 1: 23-word I segment at base 0
    words.delete();
    words.push_back(32'h2008_0005);
    for (int i = 1; i < 23; i++) words.push_back(32'hA000_0000 | (32'(i) * 32'h0101));
    send_seg(8'h49, 16'h0000);
    check("t1_ipulses", 64'(i_pulses), 64'd23);
    check("t1_dpulses", 64'(d_pulses), 64'd0);
    check("t1_last_iaddr", {32'd0, bus.IAddr_in}, 64'd22);

    // 2: 5-word D segment with random valid gaps
    gaps = 1'b1;
    words.delete();
    words.push_back(32'd42);
    words.push_back(32'd23);
    words.push_back(32'd16);
    words.push_back(32'd8);
    words.push_back(32'd156);
    send_seg(8'h44, 16'h0000);
    gaps = 1'b0;
    check("t2_dpulses", 64'(d_pulses), 64'd5);
    check("t2_ipulses", 64'(i_pulses), 64'd23);

    // 3: RUN, then further bytes are ignored
    send_byte(8'h47);
    check("t3_start", {63'd0, start}, 64'd1);
    check("t3_ready", {63'd0, bus.in_ready}, 64'd0);
    ip = i_pulses;
    dp = d_pulses;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h49;
    repeat (20) @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_no_strobe", 64'(i_pulses + d_pulses), 64'(ip + dp));
    check("t3_start_hold", {62'd0, start, bus.in_ready}, {62'd0, 2'b10});

    // 4a: illegal command byte
    do_reset();
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check("t4a_err", {61'd0, error, bus.in_ready, start}, {61'd0, 3'b100});

    // 4b: D segment 254+4 overruns DMEM_DEPTH=256
    do_reset();
    dp = d_pulses;
    send_byte(8'h44);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hFE);
    check("t4b_err", {61'd0, error, bus.in_ready, busy}, {61'd0, 3'b100});
    repeat (10) @(negedge clk);
    check("t4b_no_dwe", 64'(d_pulses), 64'(dp));

    // 5: reset in the middle of a word, then resend the whole frame
    do_reset();
    ip = i_pulses;
    send_byte(8'h49);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    repeat (4) @(negedge clk);
    check("t5_no_strobe", 64'(i_pulses), 64'(ip));
    words.delete();
    words.push_back(32'hAABB_CCDD);
    send_seg(8'h49, 16'h0003);
    check("t5_resend", 64'(i_pulses), 64'(ip + 1));

    // 6: zero-count frame returns to IDLE, then RUN
    do_reset();
    ip = i_pulses;
    words.delete();
    send_seg(8'h49, 16'h0000);
    check("t6_idle", {61'd0, busy, bus.in_ready, error}, {61'd0, 3'b010});
    check("t6_no_strobe", 64'(i_pulses), 64'(ip));
    send_byte(8'h47);
    check("t6_start", {63'd0, start}, 64'd1);

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
